// File: rtl/nn_conv_accum.sv
// nn_conv_accum: accumulates unsigned products into one signed partial sum per
// output pixel, adds a per-filter bias, rounds and shifts right, then saturates
// to a signed OUT_WIDTH activation.
// Optional build macro: NN_ACCUM_RELU_EN. When it is defined, negative
// activations are clamped to zero.
module nn_conv_accum #(
  parameter int PROD_WIDTH = 19,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic [ACC_WIDTH-1:0]  cfg_bias,
  input  logic [4:0]            cfg_shift,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] INC_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  // Saturation bounds expressed at the rounding width (ACC_WIDTH+1 bits).
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]                  state_q, state_d;
  logic [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        len_q, len_d;
  logic [4:0]                  shift_q, shift_d;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;

  logic                        accept_s;
  logic [CNT_WIDTH-1:0]        len_in_s;
  logic [ACC_WIDTH-1:0]        prod_ext_s;
  logic signed [ACC_WIDTH:0]   acc_ext_s;
  logic signed [ACC_WIDTH:0]   round_inc_s;
  logic signed [ACC_WIDTH:0]   round_sum_s;
  logic signed [ACC_WIDTH:0]   r_s;
  logic [OUT_WIDTH-1:0]        act_s;

  // Ready is decoded from state and reset only, so no valid->ready path exists.
  assign prod_ready = ~ap_rst & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
  assign accept_s   = prod_valid & prod_ready;
  assign prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, prod_data};
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // A configured length of zero behaves as a single-product group.
  always_comb begin
    if (cfg_len == {CNT_WIDTH{1'b0}}) begin
      len_in_s = CNT_ONE;
    end else begin
      len_in_s = cfg_len;
    end
  end

  // Round-half-up at one extra bit of width, arithmetic shift, then clamp.
  always_comb begin
    acc_ext_s = {acc_q[ACC_WIDTH-1], acc_q};
    if (shift_q == 5'd0) begin
      round_inc_s = {(ACC_WIDTH+1){1'b0}};
    end else begin
      round_inc_s = INC_ONE << (shift_q - 5'd1);
    end
    round_sum_s = acc_ext_s + round_inc_s;
    r_s         = round_sum_s >>> shift_q;
`ifdef NN_ACCUM_RELU_EN
    if (r_s[ACC_WIDTH]) begin
      act_s = {OUT_WIDTH{1'b0}};
    end else if (r_s > SAT_MAX) begin
      act_s = OUT_MAX;
    end else begin
      act_s = r_s[OUT_WIDTH-1:0];
    end
`else
    if (r_s > SAT_MAX) begin
      act_s = OUT_MAX;
    end else if (r_s < SAT_MIN) begin
      act_s = OUT_MIN;
    end else begin
      act_s = r_s[OUT_WIDTH-1:0];
    end
`endif
  end

  // Next-state and datapath update for the IDLE/ACCUM/ROUND/OUT sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          acc_d   = cfg_bias + prod_ext_s;
          cnt_d   = CNT_ONE;
          len_d   = len_in_s;
          shift_d = cfg_shift;
          if (len_in_s == CNT_ONE) begin
            state_d = ST_ROUND;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = acc_q + prod_ext_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == (len_q - CNT_ONE)) begin
            state_d = ST_ROUND;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_ROUND: begin
        out_data_d  = act_s;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset; reset drops any partial group.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_WIDTH{1'b0}};
      cnt_q       <= {CNT_WIDTH{1'b0}};
      len_q       <= {CNT_WIDTH{1'b0}};
      shift_q     <= 5'd0;
      out_data_q  <= {OUT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nn_conv_accum.sv
// Self-checking bench for nn_conv_accum: directed cases plus randomized groups
// compared against an arithmetic reference of the accumulate/round/saturate rule.
module tb_nn_conv_accum;

  localparam int PW = 19;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int CW = 12;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [CW-1:0] cfg_len;
  logic [AW-1:0] cfg_bias;
  logic [4:0]    cfg_shift;
  logic          prod_valid;
  logic          prod_ready;
  logic [PW-1:0] prod_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned prods_q[$];

  always #5 ap_clk = ~ap_clk;

  nn_conv_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_len(cfg_len), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Reference: 32-bit wrapping sum, wide round-half-up, arithmetic shift, clamp.
  function automatic logic [7:0] ref_act(input logic [31:0] bias, input longint sum, input int shift);
    longint t;
    int     a32;
    longint a;
    t   = longint'($signed(bias)) + sum;
    a32 = int'(t);
    a   = longint'(a32);
    if (shift > 0) a = (a + (longint'(1) <<< (shift - 1))) >>> shift;
`ifdef NN_ACCUM_RELU_EN
    if (a < 0) a = 0;
`endif
    if (a > 127) a = 127;
    else if (a < -128) a = -128;
    return a[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Feeds one group from prods_q, checks latency/hold/handshake, returns the output.
  task automatic run_group(input int len_cfg, input logic [31:0] bias, input int shift,
                           input int hold, output logic [7:0] obs, output int first_wait);
    int n;
    longint sum;
    int g;
    logic [7:0] expv;
    n = (len_cfg == 0) ? 1 : len_cfg;
    sum = 0;
    first_wait = 0;
    obs = 8'h00;
    cfg_len = CW'(len_cfg);
    cfg_bias = bias;
    cfg_shift = 5'(shift);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        prod_valid = 1'b0;
        @(posedge ap_clk); #1;
      end
      prod_valid = 1'b1;
      prod_data = PW'(prods_q[i]);
      g = 0;
      while (!prod_ready && g < 50) begin @(posedge ap_clk); #1; g++; end
      if (i == 0) first_wait = g;
      if (g >= 50) begin
        check("accept_timeout", 64'(g), 64'd0);
        prod_valid = 1'b0;
        return;
      end
      @(posedge ap_clk); #1;
      sum += longint'(prods_q[i]);
      prod_valid = 1'b0;
      prod_data = PW'($urandom);
      if (i == 0) begin
        cfg_len = CW'($urandom);
        cfg_bias = $urandom;
        cfg_shift = 5'($urandom);
      end
    end
    expv = ref_act(bias, sum, shift);
    check("round_ready", 64'(prod_ready), 64'd0);
    check("round_valid", 64'(out_valid), 64'd0);
    prod_valid = 1'b1;
    prod_data = PW'($urandom);
    g = 0;
    while (!out_valid && g < 20) begin @(posedge ap_clk); #1; g++; end
    check("latency", 64'(g + 1), 64'd2);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(expv));
      check("hold_ready", 64'(prod_ready), 64'd0);
      @(posedge ap_clk); #1;
    end
    obs = out_data;
    check("out_data", 64'(out_data), 64'(expv));
    out_ready = 1'b1;
    prod_valid = 1'b0;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(prod_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] obs;
    int fw;
    logic [31:0] rb;
    int rl, rs, rh;

    ap_rst = 1'b1; out_ready = 1'b0; prod_valid = 1'b0; prod_data = '0;
    cfg_len = '0; cfg_bias = '0; cfg_shift = 5'd0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_ready", 64'(prod_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    ap_rst = 1'b0;
    #1;
    check("idle_ready", 64'(prod_ready), 64'd1);

    // Basic group: 4+8+12-5 = 19, (19+2)>>2 = 5.
    prods_q = '{32'd4, 32'd8, 32'd12};
    run_group(3, 32'hFFFF_FFFB, 2, 0, obs, fw);
    check("basic", 64'(obs), 64'h05);

    // Positive saturation: 300 -> 127.
    prods_q = '{32'd200, 32'd100};
    run_group(2, 32'd0, 0, 0, obs, fw);
    check("sat_pos", 64'(obs), 64'h7F);

    // Negative rounding: -990 + 4 = -986, >>>3 = -124.
    prods_q = '{32'd10};
    run_group(1, 32'hFFFF_FC18, 3, 0, obs, fw);
`ifdef NN_ACCUM_RELU_EN
    check("neg_round", 64'(obs), 64'h00);
`else
    check("neg_round", 64'(obs), 64'h84);
`endif

    // Backpressure for 5 cycles, then an immediate next group.
    prods_q = '{32'd30, 32'd40};
    run_group(2, 32'd0, 1, 5, obs, fw);
    check("bp_data", 64'(obs), 64'h23);
    prods_q = '{32'd9};
    run_group(1, 32'd1, 0, 0, obs, fw);
    check("b2b_accept_wait", 64'(fw), 64'd0);
    check("b2b_data", 64'(obs), 64'h0A);

    // Reset in the middle of a group discards the partial sum.
    cfg_len = 12'd4; cfg_bias = 32'd0; cfg_shift = 5'd0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1; prod_data = 19'd100;
      @(posedge ap_clk); #1;
    end
    prod_valid = 1'b0;
    ap_rst = 1'b1;
    #1;
    check("midrst_ready", 64'(prod_ready), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_idle", 64'(prod_ready), 64'd1);
    repeat (4) @(posedge ap_clk);
    #1;
    check("midrst_no_out", 64'(out_valid), 64'd0);
    prods_q = '{32'd7};
    run_group(1, 32'd0, 0, 0, obs, fw);
    check("post_rst", 64'(obs), 64'h07);

    // Degenerate length 0 is a single-product group.
    prods_q = '{32'd2};
    run_group(0, 32'd3, 0, 0, obs, fw);
    check("len_zero", 64'(obs), 64'h05);

    // Randomized groups against the reference.
    for (int k = 0; k < 25; k++) begin
      rl = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(0, 4000)) - 32'd2000;
      else rb = $urandom;
      if ($urandom_range(0, 1) == 1) rs = $urandom_range(0, 6);
      else rs = $urandom_range(0, 31);
      rh = $urandom_range(0, 3);
      prods_q.delete();
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 1) == 1) prods_q.push_back($urandom_range(0, 300));
        else prods_q.push_back($urandom_range(0, (1 << PW) - 1));
      end
      run_group(rl, rb, rs, rh, obs, fw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
